// File: rtl/dmem_sized.sv
// Byte-addressable data memory with sized loads/stores, fault detection and a post-reset fill sequencer.
// Latency: stores commit on the accept edge, every response appears one cycle after accept; ready is low while filling.
`timescale 1ns/1ps

module dmem_sized #(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] last_wr_addr,
  output logic [31:0]       last_wr_data,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_wdat;

  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] last_wr_addr_q;
  logic [31:0]       last_wr_data_q;

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              fault;
  logic              accept;
  logic              st_en;
  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic [31:0]       wr_lanes;
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  // Sequencer: one word per cycle, then RUN for good until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign ready     = (state_q == S_RUN);
  assign init_done = (state_q == S_RUN);
  assign accept    = req & ready;

  // Request decode and fault classification.
  assign idx          = addr[IDX_W+1:2];
  assign lane         = addr[1:0];
  assign out_of_range = |addr[ADDR_W-1:IDX_W+2];

  always_comb begin
    fault = out_of_range;
    case (size)
      2'b00:   fault = out_of_range;
      2'b01:   fault = out_of_range | addr[0];
      2'b10:   fault = out_of_range | (addr[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  assign st_en   = accept & we & ~fault;
  assign rd_word = mem_q[idx];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata;
    case (size)
      2'b00: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        wr_lanes = wdata;
      end
      default: begin
        be       = 4'b0000;
        wr_lanes = wdata;
      end
    endcase
  end

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[i*8 +: 8] = wr_lanes[i*8 +: 8];
    end
  end

  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_ext = '0;
    case (size)
      2'b00:   load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      2'b10:   load_ext = rd_word;
      default: load_ext = '0;
    endcase
  end

  assign rsp_rdata_d = (we | fault) ? 32'h0 : load_ext;

  // Single write port shared between the fill sequencer and committed stores.
  always_comb begin
    mem_we   = st_en;
    mem_idx  = idx;
    mem_wdat = merged;
    if (state_q == S_INIT) begin
      mem_we   = 1'b1;
      mem_idx  = cnt_q;
      mem_wdat = (INIT_MODE != 0) ? 32'(cnt_q) : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      last_wr_addr_q <= '0;
      last_wr_data_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= fault;
      end
      if (st_en) begin
        last_wr_addr_q <= addr;
        last_wr_data_q <= merged;
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign last_wr_addr = last_wr_addr_q;
  assign last_wr_data = last_wr_data_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: a default instance plus a small zero-filled instance.
`timescale 1ns/1ps

module tb_dmem_sized;

  logic        clk;
  logic        rst;
  logic        req, req2;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ready, rsp_valid, rsp_err, init_done;
  logic [31:0] rsp_rdata, last_wr_addr, last_wr_data;
  logic        ready2, rsp_valid2, rsp_err2, init_done2;
  logic [31:0] rsp_rdata2, last_wr_addr2, last_wr_data2;

  int checks = 0;
  int errors = 0;

  dmem_sized #(.DEPTH(256), .ADDR_W(32), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .last_wr_addr(last_wr_addr),
    .last_wr_data(last_wr_data), .init_done(init_done)
  );

  dmem_sized #(.DEPTH(16), .ADDR_W(32), .INIT_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .ready(ready2), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .last_wr_addr(last_wr_addr2),
    .last_wr_data(last_wr_data2), .init_done(init_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One request, held for one edge; returns at edge+1 with the response visible.
  task automatic drv(input bit sel, input logic w, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    if (sel) req2 = 1'b1; else req = 1'b1;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_reset;
    int n, n2;
    rst = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; size = 2'b10;
    sign_ext = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b exp 0", init_done); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b exp 0 0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (last_wr_addr !== 32'h0 || last_wr_data !== 32'h0) begin errors++; $display("FAIL reset_last_wr: got %h %h exp 0 0", last_wr_addr, last_wr_data); end
    rst = 1'b1;
    n = 0; n2 = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (ready2 && n2 == 0) n2 = c;
      if (ready) begin n = c; break; end
    end
    checks++; if (n != 256) begin errors++; $display("FAIL init_cycles: got %0d exp 256", n); end
    checks++; if (n2 != 16) begin errors++; $display("FAIL init_cycles_small: got %0d exp 16", n2); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b exp 1", init_done); end
  endtask

  task automatic test_init_read;
    drv(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lw10_valid: got %b exp 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h4 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw10_init: got %h e=%b exp 00000004 e=0", rsp_rdata, rsp_err); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lw10_pulse: got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h4) begin errors++; $display("FAIL lw10_hold: got %h exp 00000004", rsp_rdata); end
  endtask

  task automatic test_sized;
    drv(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AB);
    checks++; if (last_wr_data !== 32'h0000AB04 || last_wr_addr !== 32'h11) begin errors++; $display("FAIL sb11_last_wr: got %h %h exp 00000011 0000ab04", last_wr_addr, last_wr_data); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL sb11_rsp: got v=%b %h e=%b exp v=1 0 e=0", rsp_valid, rsp_rdata, rsp_err); end
    drv(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checks++; if (rsp_rdata !== 32'hFFFFFFAB) begin errors++; $display("FAIL lb11: got %h exp ffffffab", rsp_rdata); end
    drv(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checks++; if (rsp_rdata !== 32'h000000AB) begin errors++; $display("FAIL lbu11: got %h exp 000000ab", rsp_rdata); end
    drv(0, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    checks++; if (rsp_rdata !== 32'h0000AB04) begin errors++; $display("FAIL lw10_after_sb: got %h exp 0000ab04", rsp_rdata); end
    drv(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001);
    checks++; if (last_wr_data !== 32'h80010008) begin errors++; $display("FAIL sh22_last_wr: got %h exp 80010008", last_wr_data); end
    drv(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    checks++; if (rsp_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh22: got %h exp ffff8001", rsp_rdata); end
    drv(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    checks++; if (rsp_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu22: got %h exp 00008001", rsp_rdata); end
    drv(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (rsp_rdata !== 32'h80010008) begin errors++; $display("FAIL lw20: got %h exp 80010008", rsp_rdata); end
    drv(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    checks++; if (rsp_rdata !== 32'h00000008) begin errors++; $display("FAIL lh20: got %h exp 00000008", rsp_rdata); end
    drv(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    checks++; if (rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb23: got %h exp ffffff80", rsp_rdata); end
    drv(0, 1'b0, 2'b10, 1'b1, 32'h0C, 32'h0);
    checks++; if (rsp_rdata !== 32'h00000003) begin errors++; $display("FAIL lw0c_untouched: got %h exp 00000003", rsp_rdata); end
  endtask

  task automatic test_faults;
    drv(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL lw12_fault: got v=%b e=%b %h exp v=1 e=1 0", rsp_valid, rsp_err, rsp_rdata); end
    drv(0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL sh13_fault: got %b exp 1", rsp_err); end
    checks++; if (last_wr_addr !== 32'h22 || last_wr_data !== 32'h80010008) begin errors++; $display("FAIL sh13_last_wr: got %h %h exp 00000022 80010008", last_wr_addr, last_wr_data); end
    drv(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (rsp_rdata !== 32'h0000AB04 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw10_after_fault: got %h e=%b exp 0000ab04 e=0", rsp_rdata, rsp_err); end
    drv(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL size11_fault: got e=%b %h exp e=1 0", rsp_err, rsp_rdata); end
    drv(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFFFFFF);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL sw400_fault: got %b exp 1", rsp_err); end
    checks++; if (last_wr_addr !== 32'h22 || last_wr_data !== 32'h80010008) begin errors++; $display("FAIL sw400_last_wr: got %h %h exp 00000022 80010008", last_wr_addr, last_wr_data); end
    drv(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL lw0_after_sw400: got %h e=%b exp 0 e=0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_store_rsp: got v=%b %h exp v=1 0", rsp_valid, rsp_rdata); end
    we = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_load_rsp: got v=%b %h exp v=1 deadbeef", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid;
    int n, bad;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h40;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", rsp_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b exp 0", ready); end
    n = 0; bad = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
      if (ready) begin n = c; break; end
    end
    req = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_init_accept: got %0d responses exp 0", bad); end
    checks++; if (n != 256) begin errors++; $display("FAIL midrst_init_cycles: got %0d exp 256", n); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_first_run: got %b exp 0", rsp_valid); end
    drv(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++; if (rsp_rdata !== 32'h00000010 || rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_lw40: got %h e=%b exp 00000010 e=0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_small;
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL small_ready: got %b exp 1", ready2); end
    drv(1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    checks++; if (rsp_valid2 !== 1'b1 || rsp_rdata2 !== 32'h0 || rsp_err2 !== 1'b0) begin errors++; $display("FAIL small_lw3c: got v=%b %h e=%b exp v=1 0 e=0", rsp_valid2, rsp_rdata2, rsp_err2); end
    drv(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    checks++; if (rsp_valid2 !== 1'b1 || rsp_err2 !== 1'b1) begin errors++; $display("FAIL small_lw40: got v=%b e=%b exp v=1 e=1", rsp_valid2, rsp_err2); end
    drv(1, 1'b1, 2'b10, 1'b0, 32'h3C, 32'hCAFEF00D);
    drv(1, 1'b0, 2'b00, 1'b1, 32'h3E, 32'h0);
    checks++; if (rsp_rdata2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL small_lb3e: got %h exp fffffffe", rsp_rdata2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL small_isolation: got %b exp 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_sized();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
